// File: rtl/seq_div_16_by_8_pkg.sv
// Shared widths, FSM encodings and constants for the 16-by-8 sequential restoring divider.
package seq_div_16_by_8_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [DEF_DW-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_div_16_by_8_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module seq_div_16_by_8_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] r_o,
  output logic          q_bit_o
);

  logic [VW:0] trial;
  logic [VW:0] diff;

  // The incoming remainder is always below the divisor, so T fits VW+1 bits and
  // whichever value is kept (T when it borrows, T-divisor otherwise) fits back in VW bits.
  always_comb begin
    trial   = {r_i, q_msb_i};
    diff    = trial - {1'b0, divisor_i};
    q_bit_o = ~diff[VW];
    r_o     = diff[VW] ? trial[VW-1:0] : diff[VW-1:0];
  end

endmodule

// File: rtl/seq_div_16_by_8.sv
// Sequential restoring divider, one quotient bit per clock under a start/busy/done handshake.
module seq_div_16_by_8
  import seq_div_16_by_8_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int CNT_W = $clog2(DW);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VW-1:0]    r_q;
  logic [DW-1:0]    q_q;
  logic [VW-1:0]    dvsr_q;
  logic             busy_q;
  logic             done_q;
  logic [DW-1:0]    quot_q;
  logic [VW-1:0]    rem_q;
  logic             dbz_q;

  logic [VW-1:0]    r_d;
  logic             q_bit;
  logic [DW-1:0]    q_d;

  seq_div_16_by_8_step #(.VW(VW)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[DW-1]),
    .divisor_i (dvsr_q),
    .r_o       (r_d),
    .q_bit_o   (q_bit)
  );

  assign q_d = {q_q[DW-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (start) begin
            if (divisor != '0) begin
              dvsr_q  <= divisor;
              q_q     <= dividend;
              r_q     <= '0;
              cnt_q   <= CNT_W'(DW - 1);
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              // Divide-by-zero resolves immediately without ever raising busy.
              quot_q  <= DBZ_QUOTIENT;
              rem_q   <= dividend[VW-1:0];
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule
